// File: rtl/op_log_arbiter.sv
// Ten-entry circular operation log shared between the time manager's writer and a
// playback reader, with round-robin arbitration, overwrite-oldest and synchronous clear.
module op_log_arbiter #(
  parameter int unsigned DEPTH = 10,
  parameter int unsigned OP_W  = 3,
  parameter int unsigned T_W   = 8,
  parameter int unsigned PTR_W = 4
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             wr_req,
  input  logic [OP_W-1:0]  wr_op,
  input  logic [T_W-1:0]   wr_min,
  input  logic [T_W-1:0]   wr_sec,
  output logic             wr_ack,
  input  logic             rd_req,
  output logic             rd_valid,
  output logic [OP_W-1:0]  rd_op,
  output logic [T_W-1:0]   rd_min,
  output logic [T_W-1:0]   rd_sec,
  output logic             rd_empty,
  input  logic             clr,
  output logic [PTR_W-1:0] count,
  output logic             overflow
);

  localparam int unsigned     E_W  = OP_W + 2 * T_W;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] FULL = PTR_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, WRITE, READ, CLEAR} state_t;

  state_t           state;
  logic [E_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             last_wr;
  logic             clr_pend;
  logic             wr_win_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Writer wins when alone, when the log is empty, or when the reader went last.
  assign wr_win_c = wr_req && (!rd_req || (count == '0) || !last_wr);

  // Log storage: not reset, written only at the end of a WRITE cycle.
  always_ff @(posedge clk) begin
    if (state == WRITE) mem[wr_ptr] <= {wr_op, wr_min, wr_sec};
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      last_wr  <= 1'b0;
      clr_pend <= 1'b0;
      wr_ack   <= 1'b0;
      rd_valid <= 1'b0;
      rd_empty <= 1'b0;
      rd_op    <= '0;
      rd_min   <= '0;
      rd_sec   <= '0;
    end else begin
      wr_ack   <= 1'b0;
      rd_valid <= 1'b0;
      rd_empty <= 1'b0;
      if (clr && (state inside {WRITE, READ})) clr_pend <= 1'b1;
      unique case (state)
        IDLE: begin
          if (clr || clr_pend) begin
            state    <= CLEAR;
            clr_pend <= 1'b0;
          end else if (wr_win_c) begin
            state   <= WRITE;
            wr_ack  <= 1'b1;
            last_wr <= 1'b1;
          end else if (rd_req) begin
            state    <= READ;
            rd_valid <= 1'b1;
            last_wr  <= 1'b0;
            // Read data is registered on entry so it is valid throughout READ.
            if (count == '0) begin
              rd_empty <= 1'b1;
              rd_op    <= '0;
              rd_min   <= '0;
              rd_sec   <= '0;
            end else begin
              {rd_op, rd_min, rd_sec} <= mem[rd_ptr];
            end
          end
        end
        WRITE: begin
          state  <= IDLE;
          wr_ptr <= ptr_inc(wr_ptr);
          if (count < FULL) begin
            count <= count + PTR_W'(1);
          end else begin
            rd_ptr   <= ptr_inc(rd_ptr);
            overflow <= 1'b1;
          end
        end
        READ: begin
          state <= IDLE;
          if (count != '0) begin
            rd_ptr <= ptr_inc(rd_ptr);
            count  <= count - PTR_W'(1);
          end
        end
        CLEAR: begin
          state    <= IDLE;
          wr_ptr   <= '0;
          rd_ptr   <= '0;
          count    <= '0;
          overflow <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
